// File: rtl/vect_pkg.sv
// Shared types and constants for the vector execute-stage capture block.
//   N, M          : lane width and lane count of the ALU result bus
//   REG_AW        : vector register address width
//   SEL_SIN/COS   : ALU selects that go through the one-cycle trig ROM
//   vect_state_t  : capture FSM states
//   vect_wb_t     : one buffered writeback entry {data, rd, we}
package vect_pkg;
    localparam int N          = 24;
    localparam int M          = 6;
    localparam int REG_AW     = 4;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    localparam logic [3:0] SEL_SIN = 4'd6;
    localparam logic [3:0] SEL_COS = 4'd7;

    typedef enum logic {IDLE, TRIG_WAIT} vect_state_t;

    typedef struct packed {
        logic [M*N-1:0]    data;
        logic [REG_AW-1:0] rd;
        logic              we;
    } vect_wb_t;

    function automatic logic is_trig(input logic [3:0] sel);
        return (sel == SEL_SIN) || (sel == SEL_COS);
    endfunction
endpackage

// File: rtl/vect_ex_capture_if.sv
// Handshake bundle between issue/ALU, the capture block and vector writeback.
//   in_*       : op presented by issue plus its ALU result and wb metadata
//   out_*      : head of the result buffer towards writeback
//   busy       : capture block holds a pending trig op or buffered results
// Modports: slave = capture block side, master = issue/writeback side.
interface vect_ex_capture_if;
    import vect_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_select;
    logic [REG_AW-1:0] in_rd;
    logic              in_we;
    logic [M*N-1:0]    alu_result;
    logic              out_valid;
    logic              out_ready;
    logic [M*N-1:0]    out_data;
    logic [REG_AW-1:0] out_rd;
    logic              out_we;
    logic              busy;

    modport slave (
        input  in_valid, in_select, in_rd, in_we, alu_result, out_ready,
        output in_ready, out_valid, out_data, out_rd, out_we, busy
    );

    modport master (
        output in_valid, in_select, in_rd, in_we, alu_result, out_ready,
        input  in_ready, out_valid, out_data, out_rd, out_we, busy
    );
endinterface

// File: rtl/vect_result_fifo.sv
// Small register FIFO of writeback entries. Entry 0 is always the head, so
// the head output comes straight from a register. Pop shifts entries down;
// push writes the first free slot after any shift in the same cycle.
//   clk, rst : clock, synchronous active-low reset (clears entries to 0)
//   push/din : enqueue (caller guarantees not full)
//   pop      : dequeue head (caller guarantees not empty)
//   head     : oldest entry, count : number of valid entries
module vect_result_fifo
    import vect_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  vect_wb_t      din,
    output vect_wb_t      head,
    output logic [CW-1:0] count
);
    vect_wb_t      ent [DEPTH];
    vect_wb_t      nxt [DEPTH];
    logic [CW-1:0] wr_idx;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        // After a simultaneous pop, the free slot moves down by one.
        wr_idx = count - CW'(pop);
        for (int i = 0; i < DEPTH; i++) nxt[i] = ent[i];
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) nxt[i] = ent[i+1];
            nxt[DEPTH-1] = '0;
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++)
                if (CW'(i) == wr_idx) nxt[i] = din;
        end
        cnt_nxt = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= nxt[i];
            count <= cnt_nxt;
        end
    end

    assign head = ent[0];
endmodule

// File: rtl/vect_ex_capture.sv
// Execute-stage capture: samples the ALU result with its writeback metadata,
// stalls sin/cos ops one cycle for the trig ROM, and queues results in a
// 2-entry buffer towards vector writeback.
//   clk  : system clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : vect_ex_capture_if.slave (issue handshake, ALU result, wb output)
module vect_ex_capture
    import vect_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    vect_ex_capture_if.slave    bus
);
    vect_state_t      state;
    logic [CNT_W-1:0] count;
    vect_wb_t         head;
    vect_wb_t         din;
    logic             trig;
    logic             room;
    logic             push;
    logic             pop;

    assign trig = is_trig(bus.in_select);
    assign room = (count != CNT_W'(FIFO_DEPTH));

    // A trig op seen in IDLE is held off for one cycle so the ROM output is
    // on alu_result when it is finally accepted from TRIG_WAIT.
    always_comb begin
        bus.in_ready = 1'b0;
        if (rst) begin
            if (state == IDLE) bus.in_ready = !trig && room;
            else               bus.in_ready = room;
        end
    end

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;
    assign din  = '{data: bus.alu_result, rd: bus.in_rd, we: bus.in_we};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:      if (bus.in_valid && trig) state <= TRIG_WAIT;
                // Leave on acceptance, or if issue withdrew the op.
                TRIG_WAIT: if (!bus.in_valid || push) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    vect_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .count (count)
    );

    assign bus.out_valid = (count != '0);
    assign bus.out_data  = head.data;
    assign bus.out_rd    = head.rd;
    assign bus.out_we    = head.we;
    assign bus.busy      = (state == TRIG_WAIT) || (count != '0);
endmodule

// File: doc/vect_ex_capture.md
# vect_ex_capture

Execute-stage capture block directly downstream of the 6-lane vector ALU. It samples the ALU result together with the instruction's writeback metadata and handles the one-cycle sin/cos ROM latency by holding trig ops for an extra cycle. Results are queued in a 2-entry buffer and presented to vector writeback with a valid/ready handshake.

## Interface

- N, 24, lane width in bits
- M, 6, number of lanes
- REG_AW, 4, vector register address width
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  upstream issue has an op whose operands are driven into the ALU this cycle
- in_ready  out  1  op is accepted this cycle when in_valid && in_ready
- in_select  in  4  ALU select of the presented op
- in_rd  in  REG_AW  destination vector register
- in_we  in  1  op writes back
- alu_result  in  M*N  ALU result bus (lane k at [k*N +: N])
- out_valid  out  1  head entry valid
- out_ready  in  1  writeback consumes head when out_valid && out_ready
- out_data  out  M*N  head result
- out_rd  out  REG_AW  head destination
- out_we  out  1  head write enable
- busy  out  1  TRIG_WAIT active or buffer non-empty

## Operation

- FSM states: IDLE, TRIG_WAIT.
- An op is trig when in_select is SEL_SIN or SEL_COS; all other selects are plain.
- IDLE, plain op: in_ready = (count < 2). On handshake, push {alu_result, in_rd, in_we}.
- IDLE, trig op: in_ready = 0; go to TRIG_WAIT. The ROM registers the address this cycle.
- TRIG_WAIT: in_ready = (count < 2). On handshake, push {alu_result, in_rd, in_we} and go to IDLE. Without a handshake because the buffer is full, stay in TRIG_WAIT.
- TRIG_WAIT with in_valid = 0 (protocol violation): go to IDLE, push nothing. The bench flags a change of in_select/in_rd during TRIG_WAIT as an error.
- Each trig op completes exactly one handshake.
- Buffer: 2 entries, FIFO order. The head drives the out_* ports directly from registers.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Push never occurs at count = 2, because in_ready is low.
- in_ready depends only on state, count and in_select. It has no combinational path from out_ready.
- busy = (state == TRIG_WAIT) || (count != 0).
- No arithmetic is done on data. Widths pass through unchanged.

## Timing

- Reset (rst = 0 at a rising edge):
  - state is IDLE, count is 0.
  - out_valid, out_data, out_rd, out_we and busy are all 0.
  - in_ready is forced to 0 while rst = 0.
- Plain op latency: accepted at cycle T with the buffer empty gives out_valid = 1 at T+1.
- Trig op latency: presented at T, in_ready = 1 at T+1, accepted at T+1, out_valid = 1 at T+2.
- Throughput:
  - Plain ops: 1 per cycle while writeback keeps out_ready high.
  - Trig ops: 1 per 2 cycles.
- Back-pressure: with out_ready low, two ops are accepted, then in_ready drops the following cycle. One pop re-opens in_ready in the next cycle.
- Reset asserted mid-operation (in TRIG_WAIT or with a full buffer) discards all state on that edge. No partial output is produced.

## Structure

- vect_pkg holds:
  - SEL_SIN = 4'd6 and SEL_COS = 4'd7.
  - Lane constants N = 24 and M = 6.
  - The state enum {IDLE, TRIG_WAIT}.
  - Packed struct vect_wb_t {data[M*N-1:0], rd, we}.
- One sub-module, vect_result_fifo: a parameterised 2-entry register FIFO of vect_wb_t with push, pop, count, and head outputs.
- The FSM and the in_ready logic live in the top module.

## Test plan

- Reset: hold rst = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, out_valid = 0, busy = 0 throughout; after release, in_ready = 1.
- Plain op: select 4'd0, rd = 3, alu_result = 144'hA5 at T, out_ready = 1 -> at T+1 out_valid = 1, out_data = 144'hA5, out_rd = 3, out_we = 1; at T+2 out_valid = 0.
- Trig op: SEL_SIN presented at T, result driven 24'h000123 in every lane at T+1 -> in_ready = 0 at T, 1 at T+1; out_data has 24'h000123 in every lane at T+2.
- Back-pressure: out_ready = 0, plain ops with rd = 1, 2, 3 -> rd 1 and 2 accepted, in_ready = 0 on the third; raising out_ready yields rd 1, 2, 3 in order with no loss.
- Trig stall on full buffer: buffer full, SEL_COS presented -> stays in TRIG_WAIT with in_ready = 0 until a pop, then accepted the following cycle; busy = 1 throughout.
- Reset mid-TRIG_WAIT with one entry buffered -> next cycle out_valid = 0, busy = 0, state IDLE.
